// File: rtl/ip_hdr_csum_arbiter.sv
// rtl/ip_hdr_csum_arbiter.sv - round-robin arbiter sharing one IPv4 header checksum engine among packet sources
module ip_hdr_csum_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int CRC_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_vld,
    input  logic [NUM_REQ*32-1:0]   req_data,
    input  logic [NUM_REQ-1:0]      req_last,
    output logic [NUM_REQ-1:0]      req_rdy,
    output logic [NUM_REQ-1:0]      resp_vld,
    output logic [15:0]             resp_crc,
    output logic                    resp_err,
    output logic                    eng_start,
    output logic [31:0]             eng_d_in,
    output logic                    eng_d_in_vld,
    input  logic [15:0]             eng_crc,
    input  logic                    eng_crc_vld
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(CRC_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        XFER     = 3'd2,
        WAIT_CRC = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   gnt, gnt_nxt;
    logic [IW-1:0]   rr, rr_nxt;
    logic            crc_seen, crc_seen_nxt;
    logic [15:0]     crc_q, crc_q_nxt;
    logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;

    logic [NUM_REQ-1:0] req_rdy_nxt;
    logic [NUM_REQ-1:0] resp_vld_nxt;
    logic [15:0]        resp_crc_nxt;
    logic               resp_err_nxt;
    logic               eng_start_nxt;
    logic [31:0]        eng_d_in_nxt;
    logic               eng_d_in_vld_nxt;

    logic            arb_found;
    logic [IW-1:0]   arb_idx;
    logic [IW:0]     arb_sum;
    logic [IW-1:0]   arb_cand;

    logic [31:0]     sel_data;
    logic            sel_vld;
    logic            sel_last;
    logic            sel_rdy;
    logic            accept;
    logic            seen_now;
    logic [15:0]     crc_now;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (idx == IW'(i)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Round-robin search: first requesting source at or above rr, wrapping around
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_sum   = '0;
        arb_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arb_sum = {1'b0, rr} + (IW+1)'(k);
            if (arb_sum >= (IW+1)'(NUM_REQ)) begin
                arb_sum = arb_sum - (IW+1)'(NUM_REQ);
            end
            arb_cand = arb_sum[IW-1:0];
            if (!arb_found && req_vld[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    // Select the granted source's word, valid, last and ready
    always_comb begin
        sel_data = '0;
        sel_vld  = 1'b0;
        sel_last = 1'b0;
        sel_rdy  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt == IW'(i)) begin
                sel_data = req_data[32*i +: 32];
                sel_vld  = req_vld[i];
                sel_last = req_last[i];
                sel_rdy  = req_rdy[i];
            end
        end
    end

    // Next-state logic; every output is computed here and registered below
    always_comb begin
        state_nxt        = state;
        gnt_nxt          = gnt;
        rr_nxt           = rr;
        crc_seen_nxt     = crc_seen;
        crc_q_nxt        = crc_q;
        cnt_nxt          = '0;
        cnt_inc          = cnt + CW'(1);
        resp_crc_nxt     = '0;
        resp_err_nxt     = 1'b0;
        eng_d_in_nxt     = eng_d_in;
        eng_d_in_vld_nxt = 1'b0;
        accept           = (state == XFER) && sel_vld && sel_rdy;
        seen_now         = crc_seen | eng_crc_vld;
        crc_now          = eng_crc_vld ? eng_crc : crc_q;

        case (state)
            IDLE: begin
                if (arb_found) begin
                    gnt_nxt      = arb_idx;
                    crc_seen_nxt = 1'b0;
                    state_nxt    = START;
                end
            end
            START: begin
                if (eng_crc_vld) begin
                    crc_seen_nxt = 1'b1;
                    crc_q_nxt    = eng_crc;
                end
                state_nxt = XFER;
            end
            XFER: begin
                // The engine may report after the header, before the packet ends
                if (eng_crc_vld) begin
                    crc_seen_nxt = 1'b1;
                    crc_q_nxt    = eng_crc;
                end
                if (accept) begin
                    eng_d_in_nxt     = sel_data;
                    eng_d_in_vld_nxt = 1'b1;
                    if (sel_last) begin
                        if (seen_now) begin
                            resp_crc_nxt = crc_now;
                            state_nxt    = RESP;
                        end else begin
                            state_nxt = WAIT_CRC;
                        end
                    end
                end
            end
            WAIT_CRC: begin
                cnt_nxt = cnt_inc;
                if (eng_crc_vld) begin
                    crc_seen_nxt = 1'b1;
                    crc_q_nxt    = eng_crc;
                    resp_crc_nxt = eng_crc;
                    state_nxt    = RESP;
                end else if (cnt_inc == CW'(CRC_TIMEOUT)) begin
                    resp_crc_nxt = '0;
                    resp_err_nxt = 1'b1;
                    state_nxt    = RESP;
                end
            end
            RESP: begin
                rr_nxt    = (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + IW'(1);
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        req_rdy_nxt   = (state_nxt == XFER) ? onehot(gnt_nxt) : '0;
        resp_vld_nxt  = (state_nxt == RESP) ? onehot(gnt_nxt) : '0;
        eng_start_nxt = (state_nxt == START);
    end

    // State, bookkeeping and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            gnt          <= '0;
            rr           <= '0;
            crc_seen     <= 1'b0;
            crc_q        <= '0;
            cnt          <= '0;
            req_rdy      <= '0;
            resp_vld     <= '0;
            resp_crc     <= '0;
            resp_err     <= 1'b0;
            eng_start    <= 1'b0;
            eng_d_in     <= '0;
            eng_d_in_vld <= 1'b0;
        end else begin
            state        <= state_nxt;
            gnt          <= gnt_nxt;
            rr           <= rr_nxt;
            crc_seen     <= crc_seen_nxt;
            crc_q        <= crc_q_nxt;
            cnt          <= cnt_nxt;
            req_rdy      <= req_rdy_nxt;
            resp_vld     <= resp_vld_nxt;
            resp_crc     <= resp_crc_nxt;
            resp_err     <= resp_err_nxt;
            eng_start    <= eng_start_nxt;
            eng_d_in     <= eng_d_in_nxt;
            eng_d_in_vld <= eng_d_in_vld_nxt;
        end
    end

endmodule
